// File: rtl/nidhogg_pkg.sv
// Shared types and constants for the duel round controller.
package nidhogg_pkg;

  localparam int SCORE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [1:0] WINNER_NONE = 2'd0;
  localparam logic [1:0] WINNER_P1   = 2'd1;
  localparam logic [1:0] WINNER_P2   = 2'd2;

  // Scores never pass the limit, so a score at the limit stays put.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                 input logic [SCORE_W-1:0] lim);
    return (s >= lim) ? lim : s + 1'b1;
  endfunction

endpackage

// File: rtl/respawn_counter.sv
// Per-player death countdown: load on kill, count down, pulse expire while the count sits at 1.
// The player's alive flag is raised by the parent on the edge that ends the pulse.
module respawn_counter #(
  parameter int DEATH_CYCLES = 134217700,
  parameter int CNT_W        = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  output logic expire
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DEATH_CYCLES);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(2);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else if (load) begin
      cnt    <= LOAD_VAL;
      expire <= 1'b0;
    end else begin
      if (cnt != '0)
        cnt <= cnt - 1'b1;
      expire <= (cnt == PRE_LAST);
    end
  end

endmodule

// File: rtl/round_controller.sv
// Two-player duel round sequencer: kills, scoring, respawn timing and game end.
// DOUBLE_KO_EN: simultaneous valid hits kill both players instead of round-robin arbitration.
module round_controller
  import nidhogg_pkg::*;
#(
  parameter int DEATH_CYCLES = 134217700,
  parameter int WIN_SCORE    = 5,
  parameter int CNT_W        = 27
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               hit_p1,
  input  logic               hit_p2,
  output logic               p1_alive,
  output logic               p2_alive,
  output logic               p1_respawn,
  output logic               p2_respawn,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  state_t             state;
  logic               valid1, valid2, kill1, kill2;
  logic [SCORE_W-1:0] nxt_s1, nxt_s2;
  logic               win1, win2, end_game, clear_cnt;

  assign valid1 = (state == PLAY) && hit_p1 && p1_alive;
  assign valid2 = (state == PLAY) && hit_p2 && p2_alive;

`ifdef DOUBLE_KO_EN
  assign kill1 = valid1;
  assign kill2 = valid2;
`else
  // prio = 0 means player 1 loses the next tie.
  logic prio;
  logic tie;
  assign tie   = valid1 && valid2;
  assign kill1 = valid1 && (!tie || !prio);
  assign kill2 = valid2 && (!tie || prio);

  always_ff @(posedge clk) begin
    if (reset)
      prio <= 1'b0;
    else if (tie)
      prio <= ~prio;
  end
`endif

  // Killing one player credits the other.
  assign nxt_s1    = kill2 ? sat_inc(score_p1, WIN) : score_p1;
  assign nxt_s2    = kill1 ? sat_inc(score_p2, WIN) : score_p2;
  assign win1      = (nxt_s1 == WIN);
  assign win2      = (nxt_s2 == WIN);
  assign end_game  = (state == PLAY) && (win1 || win2);
  assign clear_cnt = (state != PLAY) || end_game;

  respawn_counter #(.DEATH_CYCLES(DEATH_CYCLES), .CNT_W(CNT_W)) u_cnt_p1 (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear_cnt),
    .load   (kill1),
    .expire (p1_respawn)
  );

  respawn_counter #(.DEATH_CYCLES(DEATH_CYCLES), .CNT_W(CNT_W)) u_cnt_p2 (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear_cnt),
    .load   (kill2),
    .expire (p2_respawn)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      p1_alive  <= 1'b0;
      p2_alive  <= 1'b0;
      score_p1  <= '0;
      score_p2  <= '0;
      game_over <= 1'b0;
      winner    <= WINNER_NONE;
    end else begin
      unique case (state)
        IDLE, OVER: begin
          if (start) begin
            state     <= PLAY;
            p1_alive  <= 1'b1;
            p2_alive  <= 1'b1;
            score_p1  <= '0;
            score_p2  <= '0;
            game_over <= 1'b0;
            winner    <= WINNER_NONE;
          end
        end
        PLAY: begin
          score_p1 <= nxt_s1;
          score_p2 <= nxt_s2;
          if (end_game) begin
            state     <= OVER;
            p1_alive  <= 1'b0;
            p2_alive  <= 1'b0;
            game_over <= 1'b1;
            winner    <= (win1 && win2) ? WINNER_NONE : (win1 ? WINNER_P1 : WINNER_P2);
          end else begin
            if (kill1)           p1_alive <= 1'b0;
            else if (p1_respawn) p1_alive <= 1'b1;
            if (kill2)           p2_alive <= 1'b0;
            else if (p2_respawn) p2_alive <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
